// File: rtl/div_sequencer_if.sv
// Execute-stage handshake between the pipeline and the iterative divider.
// The pipeline side uses the master modport; the divider uses the slave modport.
interface div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            StartE;
    logic [2:0]      Funct3E;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            StallDiv;
    logic            BusyDiv;
    logic            DoneDiv;
    logic [XLEN-1:0] ResultDiv;

    modport master (
        output StartE, Funct3E, SrcAE, SrcBE, FlushE,
        input  StallDiv, BusyDiv, DoneDiv, ResultDiv
    );

    modport slave (
        input  StartE, Funct3E, SrcAE, SrcBE, FlushE,
        output StallDiv, BusyDiv, DoneDiv, ResultDiv
    );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider and stall controller for RV32M DIV/DIVU/REM/REMU.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero, overflow and |a|<|b| in one cycle.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    div_sequencer_if.slave div
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          stateQ, stateD;
    logic [XLEN-1:0] remQ, remD;
    logic [XLEN-1:0] quoQ, quoD;
    logic [XLEN-1:0] divisorQ, divisorD;
    logic [XLEN-1:0] resultQ, resultD;
    logic [CW-1:0]   countQ, countD;
    logic            negQuoQ, negQuoD;
    logic            negRemQ, negRemD;
    logic            remSelQ, remSelD;

    logic            isSigned, wantRem, accept;
    logic [XLEN-1:0] absA, absB;

    // Undefined funct3 codes fall through as unsigned quotient (DIVU).
    assign isSigned = (div.Funct3E == 3'b100) || (div.Funct3E == 3'b110);
    assign wantRem  = (div.Funct3E == 3'b110) || (div.Funct3E == 3'b111);
    assign absA     = (isSigned && div.SrcAE[XLEN-1]) ? -div.SrcAE : div.SrcAE;
    assign absB     = (isSigned && div.SrcBE[XLEN-1]) ? -div.SrcBE : div.SrcBE;
    assign accept   = div.StartE && !div.FlushE;

    logic [XLEN:0]   trial;
    logic [XLEN-1:0] stepRem, stepQuo, fixQuo, fixRem, calcResult;

    assign trial   = {remQ, quoQ[XLEN-1]} - {1'b0, divisorQ};
    assign stepRem = trial[XLEN] ? {remQ[XLEN-2:0], quoQ[XLEN-1]} : trial[XLEN-1:0];
    assign stepQuo = {quoQ[XLEN-2:0], ~trial[XLEN]};

    // A zero divisor leaves an all-ones quotient that must not be negated.
    assign fixQuo     = (negQuoQ && (divisorQ != '0)) ? -stepQuo : stepQuo;
    assign fixRem     = negRemQ ? -stepRem : stepRem;
    assign calcResult = remSelQ ? fixRem : fixQuo;

`ifdef DIV_EARLY_OUT_EN
    logic            divZero, overflow, small, earlyOut;
    logic [XLEN-1:0] earlyResult;

    assign divZero  = (div.SrcBE == '0);
    assign overflow = isSigned && (div.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (div.SrcBE == '1);
    assign small    = (absA < absB);
    assign earlyOut = divZero || overflow || small;

    always_comb begin
        earlyResult = '0;
        if (divZero) begin
            earlyResult = wantRem ? div.SrcAE : '1;
        end else if (overflow) begin
            earlyResult = wantRem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            earlyResult = wantRem ? div.SrcAE : '0;
        end
    end
`endif

    always_comb begin
        stateD   = stateQ;
        remD     = remQ;
        quoD     = quoQ;
        divisorD = divisorQ;
        resultD  = resultQ;
        countD   = countQ;
        negQuoD  = negQuoQ;
        negRemD  = negRemQ;
        remSelD  = remSelQ;
        // Flush wins over a new start and over finishing the last iteration.
        if (div.FlushE) begin
            stateD = IDLE;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    if (accept) begin
                        remD     = '0;
                        quoD     = absA;
                        divisorD = absB;
                        countD   = '0;
                        negQuoD  = isSigned && (div.SrcAE[XLEN-1] ^ div.SrcBE[XLEN-1]);
                        negRemD  = isSigned && div.SrcAE[XLEN-1];
                        remSelD  = wantRem;
                        stateD   = CALC;
`ifdef DIV_EARLY_OUT_EN
                        if (earlyOut) begin
                            resultD = earlyResult;
                            stateD  = DONE;
                        end
`endif
                    end
                end
                CALC: begin
                    remD   = stepRem;
                    quoD   = stepQuo;
                    countD = countQ + 1'b1;
                    if (countQ == CW'(XLEN-1)) begin
                        resultD = calcResult;
                        stateD  = DONE;
                    end
                end
                DONE: stateD = IDLE;
                default: stateD = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= IDLE;
            remQ     <= '0;
            quoQ     <= '0;
            divisorQ <= '0;
            resultQ  <= '0;
            countQ   <= '0;
            negQuoQ  <= 1'b0;
            negRemQ  <= 1'b0;
            remSelQ  <= 1'b0;
        end else begin
            stateQ   <= stateD;
            remQ     <= remD;
            quoQ     <= quoD;
            divisorQ <= divisorD;
            resultQ  <= resultD;
            countQ   <= countD;
            negQuoQ  <= negQuoD;
            negRemQ  <= negRemD;
            remSelQ  <= remSelD;
        end
    end

    assign div.StallDiv  = rst_n && !div.FlushE &&
                           (((stateQ == IDLE) && div.StartE) || (stateQ == CALC));
    assign div.BusyDiv   = (stateQ == CALC);
    assign div.DoneDiv   = (stateQ == DONE) && !div.FlushE;
    assign div.ResultDiv = resultQ;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: latency, signed/unsigned results,
// special cases, flush, asynchronous reset and held/back-to-back starts.
module tb_div_sequencer;
    localparam int XLEN     = 32;
    localparam int FULL_LAT = XLEN + 1;
`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = FULL_LAT;
`endif

    logic clk;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;

    div_sequencer_if #(.XLEN(XLEN)) bus ();

    div_sequencer #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    // Issues one divide, releases StartE after the accept edge and waits for DoneDiv.
    task automatic runDiv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stallCycles);
        @(negedge clk);
        bus.StartE  = 1'b1;
        bus.Funct3E = f3;
        bus.SrcAE   = a;
        bus.SrcBE   = b;
        @(posedge clk);
        #1 bus.StartE = 1'b0;
        lat         = 0;
        stallCycles = 0;
        res         = '0;
        for (int i = 1; i <= FULL_LAT + 8; i++) begin
            @(negedge clk);
            if (bus.DoneDiv) begin
                lat = i;
                res = bus.ResultDiv;
                break;
            end
            if (bus.StallDiv) stallCycles++;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.StartE  = 1'b0;
        bus.FlushE  = 1'b0;
        bus.Funct3E = 3'b101;
        bus.SrcAE   = '0;
        bus.SrcBE   = '0;
        repeat (3) @(negedge clk);
        compared++;
        if (bus.StallDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall got=%b exp=0", bus.StallDiv); end
        compared++;
        if (bus.BusyDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.BusyDiv); end
        compared++;
        if (bus.DoneDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got=%b exp=0", bus.DoneDiv); end
        compared++;
        if (bus.ResultDiv !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_result got=%h exp=00000000", bus.ResultDiv); end
        rst_n = 1'b1;
        @(negedge clk);
        bus.StartE = 1'b1;
        #1;
        compared++;
        if (bus.StallDiv !== 1'b1) begin mismatched++; $display("[TB] FAIL idle_start_stall got=%b exp=1", bus.StallDiv); end
        bus.FlushE = 1'b1;
        #1;
        compared++;
        if (bus.StallDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_flush_stall got=%b exp=0", bus.StallDiv); end
        @(posedge clk);
        #1;
        bus.StartE = 1'b0;
        bus.FlushE = 1'b0;
        compared++;
        if (bus.BusyDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL flushed_start_busy got=%b exp=0", bus.BusyDiv); end
    endtask

    task automatic test_divu_latency();
        logic [31:0] res;
        int lat, stalls;
        runDiv(3'b101, 32'd100, 32'd7, res, lat, stalls);
        compared++;
        if (res !== 32'd14) begin mismatched++; $display("[TB] FAIL divu_100_7 result got=%h exp=%h", res, 32'd14); end
        compared++;
        if (lat !== FULL_LAT) begin mismatched++; $display("[TB] FAIL divu_100_7 latency got=%0d exp=%0d", lat, FULL_LAT); end
        compared++;
        if (stalls !== XLEN) begin mismatched++; $display("[TB] FAIL divu_100_7 stall_cycles got=%0d exp=%0d", stalls, XLEN); end
        compared++;
        if (bus.StallDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL done_cycle_stall got=%b exp=0", bus.StallDiv); end
        compared++;
        if (bus.BusyDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL done_cycle_busy got=%b exp=0", bus.BusyDiv); end
        @(negedge clk);
        compared++;
        if (bus.DoneDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL done_one_cycle got=%b exp=0", bus.DoneDiv); end
    endtask

    task automatic test_signed();
        vec_t vecs[6];
        logic [31:0] res;
        int lat, stalls;
        vecs[0] = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, FULL_LAT};
        vecs[1] = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, FULL_LAT};
        vecs[2] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL_LAT};
        vecs[3] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         FULL_LAT};
        vecs[4] = '{3'b111, 32'd100,       32'd7,         32'd2,         FULL_LAT};
        vecs[5] = '{3'b101, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, FULL_LAT};
        for (int i = 0; i < 6; i++) begin
            runDiv(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, stalls);
            compared++;
            if (res !== vecs[i].exp) begin
                mismatched++;
                $display("[TB] FAIL signed_vec%0d f3=%b a=%h b=%h result got=%h exp=%h",
                         i, vecs[i].f3, vecs[i].a, vecs[i].b, res, vecs[i].exp);
            end
            compared++;
            if (lat !== vecs[i].lat) begin mismatched++; $display("[TB] FAIL signed_vec%0d latency got=%0d exp=%0d", i, lat, vecs[i].lat); end
        end
    endtask

    task automatic test_special_cases();
        vec_t vecs[7];
        logic [31:0] res;
        int lat, stalls;
        vecs[0] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, SPECIAL_LAT};
        vecs[1] = '{3'b111, 32'd5,         32'd0,         32'd5,         SPECIAL_LAT};
        vecs[2] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, SPECIAL_LAT};
        vecs[3] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT};
        vecs[4] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPECIAL_LAT};
        vecs[5] = '{3'b101, 32'd3,         32'd10,        32'd0,         SPECIAL_LAT};
        vecs[6] = '{3'b110, 32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFD, SPECIAL_LAT};
        for (int i = 0; i < 7; i++) begin
            runDiv(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, stalls);
            compared++;
            if (res !== vecs[i].exp) begin
                mismatched++;
                $display("[TB] FAIL special_vec%0d f3=%b a=%h b=%h result got=%h exp=%h",
                         i, vecs[i].f3, vecs[i].a, vecs[i].b, res, vecs[i].exp);
            end
            compared++;
            if (lat !== vecs[i].lat) begin mismatched++; $display("[TB] FAIL special_vec%0d latency got=%0d exp=%0d", i, lat, vecs[i].lat); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, stalls;
        @(negedge clk);
        bus.StartE  = 1'b1;
        bus.Funct3E = 3'b101;
        bus.SrcAE   = 32'd1000;
        bus.SrcBE   = 32'd3;
        @(posedge clk);
        #1 bus.StartE = 1'b0;
        repeat (10) @(negedge clk);
        bus.FlushE = 1'b1;
        #1;
        compared++;
        if (bus.StallDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_stall_drop got=%b exp=0", bus.StallDiv); end
        @(posedge clk);
        #1 bus.FlushE = 1'b0;
        compared++;
        if (bus.BusyDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_to_idle busy got=%b exp=0", bus.BusyDiv); end
        compared++;
        if (bus.DoneDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_no_done got=%b exp=0", bus.DoneDiv); end
        runDiv(3'b101, 32'd9, 32'd3, res, lat, stalls);
        compared++;
        if (res !== 32'd3) begin mismatched++; $display("[TB] FAIL after_flush_divu_9_3 result got=%h exp=%h", res, 32'd3); end
        compared++;
        if (lat !== FULL_LAT) begin mismatched++; $display("[TB] FAIL after_flush_divu_9_3 latency got=%0d exp=%0d", lat, FULL_LAT); end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat, stalls;
        @(negedge clk);
        bus.StartE  = 1'b1;
        bus.Funct3E = 3'b101;
        bus.SrcAE   = 32'd1000;
        bus.SrcBE   = 32'd3;
        @(posedge clk);
        #1 bus.StartE = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (bus.StallDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL async_reset_stall got=%b exp=0", bus.StallDiv); end
        compared++;
        if (bus.BusyDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL async_reset_busy got=%b exp=0", bus.BusyDiv); end
        compared++;
        if (bus.DoneDiv !== 1'b0) begin mismatched++; $display("[TB] FAIL async_reset_done got=%b exp=0", bus.DoneDiv); end
        compared++;
        if (bus.ResultDiv !== 32'h0) begin mismatched++; $display("[TB] FAIL async_reset_result got=%h exp=00000000", bus.ResultDiv); end
        @(negedge clk);
        rst_n = 1'b1;
        runDiv(3'b101, 32'hFFFF_FFFF, 32'd1, res, lat, stalls);
        compared++;
        if (res !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL post_reset_divu result got=%h exp=ffffffff", res); end
        compared++;
        if (lat !== FULL_LAT) begin mismatched++; $display("[TB] FAIL post_reset_divu latency got=%0d exp=%0d", lat, FULL_LAT); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, heldRes;
        int lat, stalls, donePulses, doneAt;
        // StartE stays high until DoneDiv shows, so it is seen in CALC and DONE.
        @(negedge clk);
        bus.StartE  = 1'b1;
        bus.Funct3E = 3'b101;
        bus.SrcAE   = 32'd20;
        bus.SrcBE   = 32'd4;
        @(posedge clk);
        donePulses = 0;
        doneAt     = 0;
        heldRes    = '0;
        for (int i = 1; i <= FULL_LAT + 6; i++) begin
            @(negedge clk);
            if (bus.DoneDiv) begin
                donePulses++;
                doneAt     = i;
                heldRes    = bus.ResultDiv;
                bus.StartE = 1'b0;
            end
        end
        bus.StartE = 1'b0;
        compared++;
        if (donePulses !== 1) begin mismatched++; $display("[TB] FAIL held_start_pulses got=%0d exp=1", donePulses); end
        compared++;
        if (doneAt !== FULL_LAT) begin mismatched++; $display("[TB] FAIL held_start_latency got=%0d exp=%0d", doneAt, FULL_LAT); end
        compared++;
        if (heldRes !== 32'd5) begin mismatched++; $display("[TB] FAIL held_start_result got=%h exp=%h", heldRes, 32'd5); end
        runDiv(3'b101, 32'd20, 32'd4, res, lat, stalls);
        compared++;
        if (res !== 32'd5) begin mismatched++; $display("[TB] FAIL b2b_first result got=%h exp=%h", res, 32'd5); end
        runDiv(3'b111, 32'd20, 32'd6, res, lat, stalls);
        compared++;
        if (res !== 32'd2) begin mismatched++; $display("[TB] FAIL b2b_second result got=%h exp=%h", res, 32'd2); end
        compared++;
        if (lat !== FULL_LAT) begin mismatched++; $display("[TB] FAIL b2b_second latency got=%0d exp=%0d", lat, FULL_LAT); end
    endtask

    initial begin
        $display("[TB] div_sequencer bench start");
        test_reset();
        test_divu_latency();
        test_signed();
        test_special_cases();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
